// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   WORD_W, INSTR_BYTES : machine word width and instruction size in bytes
//   RESET_PC_DEF        : default reset PC
//   fetch_entry_t       : one buffered fetch (instruction word + its byte address)
//   fetch_state_t       : fetch control FSM states
package mips_pkg;

  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO holding fetched instructions for decode.
//   clk, rst : clock and synchronous active-high reset
//   push/din : write din at the tail
//   pop      : drop the head entry
//   flush    : empty the FIFO; takes priority over push and pop
//   head     : entry at the head (meaningful only when not empty)
//   full, empty, count : occupancy
module ifetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       din,
  output fetch_entry_t       head,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Storage carries no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, reads imem combinationally, buffers
// fetched words and presents them to decode over a valid/ready handshake.
//   clk, rst           : clock and synchronous active-high reset
//   pc, EnIW, imem_in  : imem read port (word returned in the same cycle)
//   stall              : hazard stall, no new fetch this cycle
//   br_taken/br_target : one-cycle redirect, flushes buffered words
//   ir, ir_pc, ir_valid, ir_ready : decode handshake
//   fetch_done         : PC is past the last imem word, fetching halted
//   misalign_err       : sticky flag for a redirect target not word aligned
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          IMEM_BYTES = 24,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  output logic        EnIW,
  input  logic [31:0] imem_in,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        fetch_done,
  output logic        misalign_err
);

  localparam int          CNT_W   = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - INSTR_BYTES);

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [31:0]      pc_next;
  logic             fetch;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     fifo_din;
  fetch_entry_t     ir_hold;

  assign ir_valid = (fifo_count != '0);
  assign pop      = ir_valid & ir_ready;

  // A full buffer can still take a word when decode drains one in the same cycle.
  assign fetch = ~rst & ~stall & ~br_taken & (state == ST_RUN) & (~fifo_full | pop);
  assign EnIW  = fetch;

  assign fifo_din = '{instr: imem_in, pc: pc};

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch),
    .pop   (pop),
    .flush (br_taken),
    .din   (fifo_din),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // RUN/HALT follow the PC that will be registered, so fetch_done is in step with pc.
  always_comb begin
    pc_next    = pc;
    state_next = state;
    if (br_taken) begin
      pc_next = {br_target[31:2], 2'b00};
    end else if (fetch) begin
      pc_next = pc + 32'(INSTR_BYTES);
    end
    state_next = (pc_next > LAST_PC) ? ST_HALT : ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      state        <= ST_RUN;
      misalign_err <= 1'b0;
      ir_hold      <= '0;
    end else begin
      pc    <= pc_next;
      state <= state_next;
      if (br_taken && (br_target[1:0] != 2'b00)) begin
        misalign_err <= 1'b1;
      end
      // Remember the last presented head so ir/ir_pc hold once the buffer empties.
      if (!fifo_empty) begin
        ir_hold <= fifo_head;
      end
    end
  end

  assign fetch_done = (state == ST_HALT);
  assign ir         = fifo_empty ? ir_hold.instr : fifo_head.instr;
  assign ir_pc      = fifo_empty ? ir_hold.pc    : fifo_head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        EnIW;
  logic [31:0] imem_in;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        fetch_done;
  logic        misalign_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:5];

  ifetch_unit #(
    .RESET_PC   (32'h0),
    .IMEM_BYTES (24),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .EnIW         (EnIW),
    .imem_in      (imem_in),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .ir_ready     (ir_ready),
    .fetch_done   (fetch_done),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  // Garbage when not enabled, so an unqualified push would show up on ir.
  assign imem_in = (EnIW && pc < 32'd24) ? mem[pc[4:2]] : 32'hdead_beef;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; ir_ready = rdy;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; ir_ready = 1'b1;
    tick();
    n_cmp++; if (EnIW !== 1'b0) begin n_err++; $display("FAIL reset_eniw: got %b want 0", EnIW); end
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", pc); end
    n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ir_valid); end
    n_cmp++; if (ir !== 32'h0 || ir_pc !== 32'h0) begin n_err++; $display("FAIL reset_ir: got %h/%h want 0/0", ir, ir_pc); end
    n_cmp++; if (fetch_done !== 1'b0 || misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_flags: got %b%b want 00", fetch_done, misalign_err); end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    n_cmp++; if (EnIW !== 1'b1 || pc !== 32'h0) begin n_err++; $display("FAIL stream_first: got en=%b pc=%h want 1/0", EnIW, pc); end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++; if (ir_valid !== 1'b1 || ir !== mem[k] || ir_pc !== 32'(4*k)) begin
        n_err++; $display("FAIL stream_word%0d: got v=%b %h@%h want 1 %h@%h", k, ir_valid, ir, ir_pc, mem[k], 32'(4*k));
      end
      n_cmp++; if (EnIW !== (k < 5)) begin n_err++; $display("FAIL stream_eniw%0d: got %b want %b", k, EnIW, (k < 5)); end
    end
    n_cmp++; if (fetch_done !== 1'b1 || pc !== 32'h18) begin n_err++; $display("FAIL stream_done: got %b pc=%h want 1 pc=18", fetch_done, pc); end
    tick();
    n_cmp++; if (ir_valid !== 1'b0 || EnIW !== 1'b0 || ir_pc !== 32'h14) begin
      n_err++; $display("FAIL stream_after: got v=%b en=%b ir_pc=%h want 0 0 14", ir_valid, EnIW, ir_pc);
    end
    tick();
    n_cmp++; if (EnIW !== 1'b0 || pc !== 32'h18) begin n_err++; $display("FAIL stream_halt: got en=%b pc=%h want 0 18", EnIW, pc); end
  endtask

  task automatic test_backpressure();
    int pulses;
    pulses = 0;
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      if (EnIW === 1'b1) pulses++;
      tick();
    end
    n_cmp++; if (pulses != 2) begin n_err++; $display("FAIL bp_pulses: got %0d want 2", pulses); end
    n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL bp_pc: got %h want 8", pc); end
    n_cmp++; if (ir_valid !== 1'b1 || ir !== 32'h0123_0000) begin n_err++; $display("FAIL bp_hold: got %b %h want 1 01230000", ir_valid, ir); end
    ir_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (ir_valid !== 1'b1 || ir !== mem[k] || ir_pc !== 32'(4*k)) begin
        n_err++; $display("FAIL bp_word%0d: got v=%b %h@%h want 1 %h@%h", k, ir_valid, ir, ir_pc, mem[k], 32'(4*k));
      end
      tick();
    end
    n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b want 0", ir_valid); end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    tick(); tick();
    br_taken = 1'b1; br_target = 32'h0c; ir_ready = 1'b1;
    #1;
    n_cmp++; if (EnIW !== 1'b0) begin n_err++; $display("FAIL br_eniw: got %b want 0", EnIW); end
    tick();
    br_taken = 1'b0;
    #1;
    n_cmp++; if (ir_valid !== 1'b0 || pc !== 32'h0c) begin n_err++; $display("FAIL br_flush: got v=%b pc=%h want 0 0c", ir_valid, pc); end
    tick();
    n_cmp++; if (ir_valid !== 1'b1 || ir !== 32'h7870_0005 || ir_pc !== 32'h0c) begin
      n_err++; $display("FAIL br_target_word: got v=%b %h@%h want 1 78700005@0c", ir_valid, ir, ir_pc);
    end
    tick();
    n_cmp++; if (ir !== 32'hfa89_0000 || ir_pc !== 32'h10) begin n_err++; $display("FAIL br_next_word: got %h@%h want fa890000@10", ir, ir_pc); end
  endtask

  task automatic test_misalign();
    do_reset(1'b1);
    repeat (7) tick();
    n_cmp++; if (fetch_done !== 1'b1) begin n_err++; $display("FAIL mis_pre_done: got %b want 1", fetch_done); end
    br_taken = 1'b1; br_target = 32'h06;
    #1;
    n_cmp++; if (EnIW !== 1'b0) begin n_err++; $display("FAIL mis_eniw: got %b want 0", EnIW); end
    tick();
    br_taken = 1'b0;
    #1;
    n_cmp++; if (pc !== 32'h4 || misalign_err !== 1'b1 || fetch_done !== 1'b0) begin
      n_err++; $display("FAIL mis_state: got pc=%h err=%b done=%b want 4 1 0", pc, misalign_err, fetch_done);
    end
    n_cmp++; if (EnIW !== 1'b1 || ir_valid !== 1'b0) begin n_err++; $display("FAIL mis_refetch: got en=%b v=%b want 1 0", EnIW, ir_valid); end
    tick();
    n_cmp++; if (ir !== 32'h1410_cbed || ir_pc !== 32'h4) begin n_err++; $display("FAIL mis_word: got %h@%h want 1410cbed@4", ir, ir_pc); end
    repeat (3) tick();
    n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_sticky: got %b want 1", misalign_err); end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    tick(); tick();
    stall = 1'b1; ir_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (EnIW !== 1'b0 || pc !== 32'h8) begin n_err++; $display("FAIL stall_frozen%0d: got en=%b pc=%h want 0 8", i, EnIW, pc); end
      n_cmp++; if (ir_valid !== (i < 2)) begin n_err++; $display("FAIL stall_valid%0d: got %b want %b", i, ir_valid, (i < 2)); end
      if (i < 2) begin
        n_cmp++; if (ir !== mem[i]) begin n_err++; $display("FAIL stall_pop%0d: got %h want %h", i, ir, mem[i]); end
      end
      tick();
    end
    stall = 1'b0;
    #1;
    n_cmp++; if (EnIW !== 1'b1 || pc !== 32'h8) begin n_err++; $display("FAIL stall_resume: got en=%b pc=%h want 1 8", EnIW, pc); end
    tick();
    n_cmp++; if (ir_valid !== 1'b1 || ir !== 32'h3765_0000 || ir_pc !== 32'h8) begin
      n_err++; $display("FAIL stall_next: got v=%b %h@%h want 1 37650000@8", ir_valid, ir, ir_pc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    br_taken = 1'b1; br_target = 32'h1;
    #1;
    tick();
    br_taken = 1'b0;
    #1;
    n_cmp++; if (misalign_err !== 1'b1 || pc !== 32'h0) begin n_err++; $display("FAIL rm_setup: got err=%b pc=%h want 1 0", misalign_err, pc); end
    tick(); tick();
    n_cmp++; if (ir_valid !== 1'b1 || pc !== 32'h8) begin n_err++; $display("FAIL rm_full: got v=%b pc=%h want 1 8", ir_valid, pc); end
    rst = 1'b1;
    #1;
    n_cmp++; if (EnIW !== 1'b0) begin n_err++; $display("FAIL rm_eniw: got %b want 0", EnIW); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (ir_valid !== 1'b0 || pc !== 32'h0 || misalign_err !== 1'b0 || fetch_done !== 1'b0) begin
      n_err++; $display("FAIL rm_state: got v=%b pc=%h err=%b done=%b want 0 0 0 0", ir_valid, pc, misalign_err, fetch_done);
    end
    n_cmp++; if (ir !== 32'h0 || ir_pc !== 32'h0) begin n_err++; $display("FAIL rm_ir: got %h/%h want 0/0", ir, ir_pc); end
    ir_ready = 1'b1;
    tick();
    n_cmp++; if (ir_valid !== 1'b1 || ir !== 32'h0123_0000 || ir_pc !== 32'h0) begin
      n_err++; $display("FAIL rm_restart: got v=%b %h@%h want 1 01230000@0", ir_valid, ir, ir_pc);
    end
  endtask

  initial begin
    mem[0] = 32'h0123_0000;
    mem[1] = 32'h1410_cbed;
    mem[2] = 32'h3765_0000;
    mem[3] = 32'h7870_0005;
    mem[4] = 32'hfa89_0000;
    mem[5] = 32'h0000_0000;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
